// File: rtl/apb_regfile_slave_if.sv
// APB bus bundle between a master and apb_regfile_slave.
// Signals: psel, penable, pwrite, paddr, pwdata, pstrb (master -> slave);
//          prdata, pready, pslverr (slave -> master).
// Clock and reset stay outside the bundle as plain module ports.
interface apb_regfile_slave_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_regfile_slave.sv
// APB register-file slave: DEPTH words, word 0 a read-only ID, words
// 1..DEPTH-1 byte-strobed read/write, WAIT_STATES wait cycles per transfer.
// Ports:
//   pclk - clock, all state on the rising edge
//   prst - synchronous active-high reset
//   bus  - apb_regfile_slave_if.slave (psel, penable, pwrite, paddr, pwdata,
//          pstrb in; prdata, pready, pslverr out, all outputs combinational)
module apb_regfile_slave #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                pclk,
  input  logic                prst,
  apb_regfile_slave_if.slave  bus
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned CNT_W = 4;
  localparam logic [DATA_WIDTH-1:0] ID_WORD = DATA_WIDTH'(ID_VALUE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // state_q remembers which phase the current cycle may continue from;
  // state_c is the bus phase of the current cycle.
  state_t                 state_q;
  state_t                 state_d;
  state_t                 state_c;
  logic [CNT_W-1:0]       wait_cnt;
  logic [CNT_W-1:0]       wait_d;

  logic [DATA_WIDTH-1:0]  regs [1:DEPTH-1];

  logic [ADDR_WIDTH-1:0]  word_idx;
  logic                   unaligned;
  logic                   out_of_range;
  logic                   err_c;
  logic                   pready_c;
  logic                   wr_en_c;
  logic [DATA_WIDTH-1:0]  rd_word_c;
  logic [DATA_WIDTH-1:0]  prdata_c;

  // Address decode
  assign word_idx     = bus.paddr >> OFF_W;
  assign unaligned    = (bus.paddr & ADDR_WIDTH'(BYTES - 1)) != '0;
  assign out_of_range = 32'(word_idx) >= DEPTH;

  // Next-state, wait counter and response
  always_comb begin
    state_c  = IDLE;
    state_d  = IDLE;
    wait_d   = '0;
    pready_c = 1'b0;
    err_c    = 1'b0;
    wr_en_c  = 1'b0;
    prdata_c = '0;

    // penable without a preceding SETUP is a violation and stays IDLE
    if (bus.psel) begin
      if (!bus.penable) begin
        state_c = SETUP;
      end else if (state_q == SETUP || state_q == ACCESS) begin
        state_c = ACCESS;
      end
    end

    if (state_c == ACCESS && wait_cnt == CNT_W'(WAIT_STATES)) begin
      pready_c = 1'b1;
    end

    if (pready_c) begin
      err_c = unaligned || out_of_range || (bus.pwrite && word_idx == '0);
    end

    wr_en_c = pready_c && bus.pwrite && !err_c;

    if (pready_c && !bus.pwrite && !err_c) begin
      prdata_c = rd_word_c;
    end

    if (state_c == ACCESS && !pready_c) begin
      wait_d = wait_cnt + CNT_W'(1);
    end

    // A completed ACCESS only continues into a fresh SETUP
    state_d = pready_c ? IDLE : state_c;
  end

  // Read mux
  always_comb begin
    rd_word_c = '0;
    if (word_idx == '0) begin
      rd_word_c = ID_WORD;
    end
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (word_idx == ADDR_WIDTH'(i)) begin
        rd_word_c = regs[i];
      end
    end
  end

  // State and wait counter
  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q  <= IDLE;
      wait_cnt <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_d;
    end
  end

  // Register storage with per-byte-lane write strobes
  always_ff @(posedge pclk) begin
    if (prst) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en_c) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (word_idx == ADDR_WIDTH'(i)) begin
          for (int unsigned k = 0; k < BYTES; k++) begin
            if (bus.pstrb[k]) begin
              regs[i][8*k +: 8] <= bus.pwdata[8*k +: 8];
            end
          end
        end
      end
    end
  end

  assign bus.pready  = pready_c;
  assign bus.pslverr = err_c;
  assign bus.prdata  = prdata_c;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Scoreboard bench: dut_a runs with WAIT_STATES=2, dut_b with WAIT_STATES=0.
module tb_apb_regfile_slave;

  logic        pclk = 1'b0;
  logic        prst = 1'b1;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        sel = 1'b0;
  logic        mon_en = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_data_a [$];
  logic        exp_err_a  [$];
  string       exp_name_a [$];
  logic [31:0] exp_data_b [$];
  logic        exp_err_b  [$];
  string       exp_name_b [$];

  always #5 pclk = ~pclk;

  apb_regfile_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus_a ();
  apb_regfile_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus_b ();

  assign bus_a.psel    = psel & ~sel;
  assign bus_a.penable = penable;
  assign bus_a.pwrite  = pwrite;
  assign bus_a.paddr   = paddr;
  assign bus_a.pwdata  = pwdata;
  assign bus_a.pstrb   = pstrb;
  assign bus_b.psel    = psel & sel;
  assign bus_b.penable = penable;
  assign bus_b.pwrite  = pwrite;
  assign bus_b.paddr   = paddr;
  assign bus_b.pwdata  = pwdata;
  assign bus_b.pstrb   = pstrb;

  apb_regfile_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_STATES(2),
    .ID_VALUE(32'hA5B0_0001)
  ) dut_a (
    .pclk(pclk), .prst(prst), .bus(bus_a)
  );

  apb_regfile_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_STATES(0),
    .ID_VALUE(32'hA5B0_0001)
  ) dut_b (
    .pclk(pclk), .prst(prst), .bus(bus_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for dut_a
  always @(negedge pclk) begin
    if (mon_en) begin
      if (bus_a.pready) begin
        if (exp_data_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_pready: got pready=1 expected no completion at %0t", $time);
        end else begin
          string nm;
          nm = exp_name_a.pop_front();
          check({nm, "_prdata"}, bus_a.prdata, exp_data_a.pop_front());
          check({nm, "_pslverr"}, 32'(bus_a.pslverr), 32'(exp_err_a.pop_front()));
        end
      end else begin
        check("a_idle_outputs", bus_a.prdata | 32'(bus_a.pslverr), 32'h0);
      end
    end
  end

  // Monitor for dut_b
  always @(negedge pclk) begin
    if (mon_en) begin
      if (bus_b.pready) begin
        if (exp_data_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_pready: got pready=1 expected no completion at %0t", $time);
        end else begin
          string nm;
          nm = exp_name_b.pop_front();
          check({nm, "_prdata"}, bus_b.prdata, exp_data_b.pop_front());
          check({nm, "_pslverr"}, 32'(bus_b.pslverr), 32'(exp_err_b.pop_front()));
        end
      end else begin
        check("b_idle_outputs", bus_b.prdata | 32'(bus_b.pslverr), 32'h0);
      end
    end
  end

  // One APB transfer; starts driving SETUP immediately, returns just after
  // the completing edge. keep=1 leaves psel high for a back-to-back transfer.
  task automatic xfer(input logic s, input logic wr, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] st,
                      input logic [31:0] exp_d, input logic exp_e,
                      input int exp_cyc, input logic keep, input string name);
    int  n;
    bit  done;
    if (s) begin
      exp_data_b.push_back(exp_d); exp_err_b.push_back(exp_e); exp_name_b.push_back(name);
    end else begin
      exp_data_a.push_back(exp_d); exp_err_a.push_back(exp_e); exp_name_a.push_back(name);
    end
    sel = s; psel = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d; pstrb = st;
    @(posedge pclk); #1;
    penable = 1'b1;
    done = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(negedge pclk);
      if (s ? bus_b.pready : bus_a.pready) begin
        done = 1'b1;
        break;
      end
      @(posedge pclk); #1;
    end
    if (done) begin
      check({name, "_access_cycles"}, 32'(n), 32'(exp_cyc));
    end else begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no pready within 20 cycles expected pready", name);
    end
    @(posedge pclk); #1;
    if (!keep) begin
      psel = 1'b0; penable = 1'b0;
    end
  endtask

  initial begin
    @(posedge pclk);
    mon_en = 1'b1;
    @(posedge pclk); #1;
    prst = 1'b0;
    @(posedge pclk); #1;

    // Basic write/read with two wait states
    xfer(0, 1, 8'h08, 32'hDEAD_BEEF, 4'hF, 32'h0,         0, 3, 0, "w08");
    xfer(0, 0, 8'h08, 32'h0,         4'h0, 32'hDEAD_BEEF, 0, 3, 0, "r08");

    // Byte strobes
    xfer(0, 1, 8'h0C, 32'h1122_3344, 4'hF,    32'h0,         0, 3, 0, "w0c_full");
    xfer(0, 1, 8'h0C, 32'hAABB_CCDD, 4'b0101, 32'h0,         0, 3, 0, "w0c_strb");
    xfer(0, 0, 8'h0C, 32'h0,         4'h0,    32'h11BB_33DD, 0, 3, 0, "r0c");

    // ID word and error cases
    xfer(0, 0, 8'h00, 32'h0,         4'h0, 32'hA5B0_0001, 0, 3, 0, "r00");
    xfer(0, 1, 8'h00, 32'h1234_5678, 4'hF, 32'h0,         1, 3, 0, "w00_err");
    xfer(0, 0, 8'h00, 32'h0,         4'h0, 32'hA5B0_0001, 0, 3, 0, "r00_again");
    xfer(0, 0, 8'h40, 32'h0,         4'h0, 32'h0,         1, 3, 0, "r40_range");
    xfer(0, 0, 8'h05, 32'h0,         4'h0, 32'h0,         1, 3, 0, "r05_unaligned");
    xfer(0, 1, 8'h0A, 32'h0BAD_0BAD, 4'hF, 32'h0,         1, 3, 0, "w0a_unaligned");
    xfer(0, 0, 8'h08, 32'h0,         4'h0, 32'hDEAD_BEEF, 0, 3, 0, "r08_intact");

    // Last word, back-to-back with wait states
    xfer(0, 1, 8'h3C, 32'h0BAD_CAFE, 4'hF, 32'h0,         0, 3, 1, "w3c");
    xfer(0, 0, 8'h3C, 32'h0,         4'h0, 32'h0BAD_CAFE, 0, 3, 0, "r3c");

    // Zero wait states, back-to-back with psel held
    xfer(1, 1, 8'h04, 32'hCAFE_F00D, 4'hF, 32'h0,         0, 1, 1, "b_w04");
    xfer(1, 0, 8'h04, 32'h0,         4'h0, 32'hCAFE_F00D, 0, 1, 0, "b_r04");

    // Reset during ACCESS cycle 2 aborts the write
    xfer(0, 1, 8'h10, 32'h1234_5678, 4'hF, 32'h0, 0, 3, 0, "w10");
    sel = 1'b0; psel = 1'b1; penable = 1'b0;
    pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h5555_5555; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    prst = 1'b1;
    @(posedge pclk); #1;
    prst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    xfer(0, 0, 8'h10, 32'h0, 4'h0, 32'h0, 0, 3, 0, "r10_after_reset");
    xfer(0, 0, 8'h08, 32'h0, 4'h0, 32'h0, 0, 3, 0, "r08_after_reset");
    xfer(1, 0, 8'h04, 32'h0, 4'h0, 32'h0, 0, 1, 0, "b_r04_after_reset");

    // psel&penable held straight out of reset: ignored until psel drops
    prst = 1'b1;
    sel = 1'b0; psel = 1'b1; penable = 1'b1;
    pwrite = 1'b1; paddr = 8'h14; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    @(posedge pclk); #1;
    prst = 1'b0;
    repeat (5) @(posedge pclk);
    #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    xfer(0, 0, 8'h14, 32'h0, 4'h0, 32'h0, 0, 3, 0, "r14_no_write");

    repeat (3) @(posedge pclk);
    check("sb_drain_a", 32'(exp_data_a.size()), 32'h0);
    check("sb_drain_b", 32'(exp_data_b.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
